// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU (add/xor/sll) between two requesters.
// Each operation runs accept -> EXEC -> RESP with a registered, handshaked response.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,

    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic             busy
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e           state;
    logic             owner;
    logic             last_grant;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic             busy_q;

    logic             grant;
    logic             accept;
    logic             rsp_handshake;

    // Arbitration: a lone requester always wins; a tie goes to the one not served last.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    // Gated by rst_n so nothing is accepted while reset is held.
    assign accept     = rst_n && (state == StIdle) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    assign rsp_handshake = owner ? rsp1_ready : rsp0_ready;

    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             op_legal;

    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;

    // Shared ALU; Zero flags inequality of the operands, not a zero result.
    always_comb begin
        alu_result = '0;
        op_legal   = 1'b1;
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SLL:  alu_result = alu_a << alu_b;
            default: op_legal   = 1'b0;
        endcase
        alu_zero = (alu_a != alu_b);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= StIdle;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        op_q       <= grant ? req1_op : req0_op;
                        a_q        <= grant ? req1_a : req0_a;
                        b_q        <= grant ? req1_b : req0_b;
                        owner      <= grant;
                        last_grant <= grant;
                        busy_q     <= 1'b1;
                        state      <= StExec;
                    end
                end
                StExec: begin
                    // Unsupported codes return 0 rather than whatever the ALU leaves on its output.
                    result_q     <= op_legal ? alu_result : '0;
                    zero_q       <= alu_zero;
                    illegal_q    <= ~op_legal;
                    rsp0_valid_q <= ~owner;
                    rsp1_valid_q <= owner;
                    state        <= StResp;
                end
                StResp: begin
                    if (rsp_handshake) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign rsp_illegal = illegal_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, random ops against a reference model,
// and hand sequences for tie alternation, response stall and reset during EXEC.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero, rsp_illegal, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_illegal(rsp_illegal),
        .busy       (busy)
    );

    typedef struct {
        bit          who;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          zero;
        bit          ill;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic z, output logic il);
        longint unsigned sum;
        z  = (a != b);
        il = 1'b0;
        case (op)
            4'b0010: begin
                sum = (longint'(a) + longint'(b)) % 64'h1_0000_0000;
                r   = sum[31:0];
            end
            4'b0011: r = a ^ b;
            4'b0100: r = (b >= 32) ? 32'h0 : (a << b[4:0]);
            default: begin
                r  = 32'h0;
                il = 1'b1;
            end
        endcase
    endfunction

    // Issue one op, check acceptance, 2-cycle latency and routing, then consume the response.
    task automatic run_op(input bit who, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag, output logic [31:0] r,
                          output logic z, output logic il);
        int waited;
        int lat;
        @(negedge clk);
        if (who) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        waited = 0;
        while (!(who ? req1_ready : req0_ready) && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check({tag, " accept wait"}, 64'(waited), 64'd0);
        check({tag, " other ready"}, 64'(who ? req0_ready : req1_ready), 64'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        while (!(rsp0_valid || rsp1_valid) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd2);
        check({tag, " rsp valids"}, 64'({rsp1_valid, rsp0_valid}), who ? 64'd2 : 64'd1);
        check({tag, " busy in resp"}, 64'(busy), 64'd1);
        r  = rsp_result;
        z  = rsp_zero;
        il = rsp_illegal;
        if (who) rsp1_ready = 1'b1;
        else     rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check({tag, " idle after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] r, er, held;
        logic        z, il, ez, eil;
        int          grants[$];
        int          gcyc[$];
        int          bad;
        int          waited;

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd3; req1_b = 32'd4;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        @(negedge clk);
        #1;
        check("reset req0_ready", 64'(req0_ready), 64'd0);
        check("reset req1_ready", 64'(req1_ready), 64'd0);
        check("reset rsp valids", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        check("reset result", 64'(rsp_result), 64'd0);
        check("reset zero/illegal/busy", 64'({rsp_zero, rsp_illegal, busy}), 64'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        vecs.push_back('{0, 4'b0010, 32'd3,         32'd2,         32'd5,         1, 0});
        vecs.push_back('{1, 4'b0011, 32'h0000_00FF, 32'h0000_00FF, 32'd0,         0, 0});
        vecs.push_back('{0, 4'b0000, 32'd7,         32'd7,         32'd0,         0, 1});
        vecs.push_back('{1, 4'b0100, 32'd1,         32'd32,        32'd0,         1, 0});
        vecs.push_back('{0, 4'b0100, 32'd1,         32'd4,         32'd16,        1, 0});
        vecs.push_back('{1, 4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1, 0});
        vecs.push_back('{0, 4'b0100, 32'd3,         32'd31,        32'h8000_0000, 1, 0});
        vecs.push_back('{1, 4'b1111, 32'd1,         32'd2,         32'd0,         1, 1});
        foreach (vecs[i]) begin
            run_op(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i),
                   r, z, il);
            check($sformatf("vec%0d result", i), 64'(r), 64'(vecs[i].res));
            check($sformatf("vec%0d zero", i), 64'(z), 64'(vecs[i].zero));
            check($sformatf("vec%0d illegal", i), 64'(il), 64'(vecs[i].ill));
        end

        for (int i = 0; i < 40; i++) begin
            bit          who;
            logic [3:0]  op;
            logic [31:0] a, b;
            who = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: op = 4'b0010;
                1: op = 4'b0011;
                2: op = 4'b0100;
                default: op = 4'($urandom);
            endcase
            a = $urandom;
            case ($urandom_range(0, 2))
                0: b = $urandom_range(0, 40);
                1: b = a;
                default: b = $urandom;
            endcase
            model(op, a, b, er, ez, eil);
            run_op(who, op, a, b, $sformatf("rnd%0d", i), r, z, il);
            check($sformatf("rnd%0d result", i), 64'(r), 64'(er));
            check($sformatf("rnd%0d zero", i), 64'(z), 64'(ez));
            check($sformatf("rnd%0d illegal", i), 64'(il), 64'(eil));
        end

        // Reset arriving while an op sits in EXEC.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd1;
        #1;
        check("rst-exec accept", 64'(req0_ready), 64'd1);
        @(negedge clk);
        check("rst-exec busy in exec", 64'(busy), 64'd1);
        rst_n = 1'b0;
        req1_valid = 1'b1;
        #1;
        check("rst-exec ready gated", 64'({req1_ready, req0_ready}), 64'd0);
        @(negedge clk);
        check("rst-exec rsp valids", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        check("rst-exec outputs", 64'({rsp_result, rsp_zero, rsp_illegal, busy}), 64'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) bad++;
        end
        check("rst-exec no response", 64'(bad), 64'd0);

        // Both requesters valid back-to-back: grants alternate starting with requester 0.
        req0_valid = 1'b1; req0_op = 4'b0100; req0_a = 32'd1;         req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready) begin grants.push_back(0); gcyc.push_back(c); end
            if (req1_ready) begin grants.push_back(1); gcyc.push_back(c); end
            if (rsp0_valid) begin
                check($sformatf("tie c%0d rsp0 result", c), 64'(rsp_result), 64'd16);
                check($sformatf("tie c%0d rsp0 zero", c), 64'(rsp_zero), 64'd1);
            end
            if (rsp1_valid) begin
                check($sformatf("tie c%0d rsp1 result", c), 64'(rsp_result), 64'd0);
                check($sformatf("tie c%0d rsp1 zero", c), 64'(rsp_zero), 64'd1);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("tie grant count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size() && i < 4; i++) begin
            check($sformatf("tie grant%0d owner", i), 64'(grants[i]), 64'(i % 2));
            check($sformatf("tie grant%0d cycle", i), 64'(gcyc[i]), 64'(3 * i));
        end
        // Drain the op granted in the last loop cycle.
        repeat (3) @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("tie drained", 64'(busy), 64'd0);

        // Response stall on requester 0 while requester 1 waits.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'b0011; req0_a = 32'd5; req0_b = 32'd3;
        #1;
        check("stall accept0", 64'(req0_ready), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd10; req1_b = 32'd20;
        waited = 0;
        while (!rsp0_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("stall rsp0 wait", 64'(waited), 64'd1);
        held = rsp_result;
        check("stall result", 64'(held), 64'd6);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (rsp_result !== held || req1_ready || !busy || !rsp0_valid || rsp1_valid) bad++;
        end
        check("stall hold", 64'(bad), 64'd0);
        rsp0_ready = 1'b1;
        #1;
        check("stall ready1 in handshake", 64'(req1_ready), 64'd0);
        @(negedge clk);
        rsp0_ready = 1'b0;
        #1;
        check("stall accept1 after handshake", 64'(req1_ready), 64'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        waited = 0;
        while (!rsp1_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("stall rsp1 wait", 64'(waited), 64'd1);
        check("stall rsp1 result", 64'(rsp_result), 64'd30);
        check("stall rsp0 low", 64'(rsp0_valid), 64'd0);
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single instance of the team's combinational `alu` between two requesters (requester 0: execute-stage integer path, requester 1: address/branch helper). Each requester issues an operation with a valid/ready handshake. The block arbitrates round-robin, latches the operands, drives the shared ALU for one cycle, and registers the result. It then returns the result to the winning requester with a valid/ready response handshake.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must equal the `alu` data width.

Ports:
- `clk`  in  1: the block's only clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `req0_valid` / `req1_valid`  in  1: requester n presents an operation.
- `req0_ready` / `req1_ready`  out  1: requester n's operation is accepted this cycle.
- `req0_op` / `req1_op`  in  4: ALU control code (0010 add, 0011 xor, 0100 sll).
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH: operands.
- `rsp0_valid` / `rsp1_valid`  out  1: result for requester n is available.
- `rsp0_ready` / `rsp1_ready`  in  1: requester n consumes its result.
- `rsp_result`  out  WIDTH: registered result, shared by both response channels.
- `rsp_zero`  out  1: registered copy of the ALU `Zero` output (1 when a != b).
- `rsp_illegal`  out  1: the op code was not one of the three supported codes.
- `busy`  out  1: high in every state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- Registers:
  - `owner`: 1 bit, the requester currently being served.
  - `last_grant`: 1 bit, round-robin pointer.
  - `op_q`, `a_q`, `b_q`: latched operation and operands.
  - `result_q`, `zero_q`, `illegal_q`: latched response.
- IDLE:
  - Arbitrate among the asserted `reqN_valid`.
  - With one valid requester, grant it.
  - With both valid, grant `!last_grant`.
  - The ready signal is asserted combinationally for the winner only, and only in IDLE.
  - On acceptance: latch op/a/b, set `owner` and `last_grant` to the winner, go to EXEC.
- EXEC:
  - The ALU inputs are driven from `op_q`/`a_q`/`b_q`.
  - For supported codes: `result_q` <= ALU result, `zero_q` <= ALU Zero, `illegal_q` <= 0.
  - For any other code: `result_q` <= 0, `zero_q` <= ALU Zero, `illegal_q` <= 1.
  - This avoids exposing the ALU's undefined output for unsupported codes.
  - Always go to RESP.
- RESP:
  - `rsp<owner>_valid` is held high; the other response valid stays low.
  - Response outputs are stable until the owner's `rspN_ready` is high.
  - On that handshake, go to IDLE.
- Arithmetic:
  - add wraps modulo 2^WIDTH; there is no carry/overflow output.
  - sll uses the full `b` value as the shift amount, so any amount >= WIDTH yields 0.
- Requests that are not granted are simply not accepted. Requesters must hold valid and payload stable until ready.
- Reset (in any state, including mid-EXEC or mid-RESP):
  - FSM returns to IDLE.
  - `last_grant` <= 1, so requester 0 wins the first tie.
  - All `*_q` registers are cleared.
  - The in-flight operation is dropped with no response.

## Timing
- Reset values: `req0_ready` = `req1_ready` = 0 while `rst_n` = 0. All response valids are 0. `rsp_result` = 0, `rsp_zero` = 0, `rsp_illegal` = 0, `busy` = 0.
- Latency: a request accepted at edge T has `rspN_valid` = 1 from cycle T+2.
- Minimum occupancy is 3 cycles per operation: accept, EXEC, RESP with immediate ready. A new acceptance can occur at the earliest in the cycle after the response handshake.
- Sustained throughput: one operation per 3 cycles.
- `reqN_ready` depends combinationally on `reqN_valid` and the state only. `rspN_valid` is registered.
- Both requesters valid every cycle: grants alternate 0, 1, 0, 1 (starvation-free).
- Response stall: the block stays in RESP indefinitely. `reqN_ready` remains 0 for both requesters.

## Test plan
- Reset, then `req0` add a=3, b=2 → `req0_ready`=1 in the accept cycle; `rsp0_valid`=1 two cycles later with result=5, zero=1, illegal=0.
- `req1` xor a=0x0000_00FF, b=0x0000_00FF → result=0, zero=0; `rsp1_valid`=1 and `rsp0_valid` stays 0.
- Both requesters valid continuously with sll a=1, b=4 (req0) and add a=0xFFFF_FFFF, b=1 (req1):
  - grant order is 0, 1, 0, 1;
  - results are 16 and 0 (wrap);
  - an operation completes every 3 cycles.
- Stall: hold `rsp0_ready`=0 for 10 cycles with `req1_valid`=1 → `rsp_result` is stable, `req1_ready` stays 0, `busy`=1; `req1` is accepted the cycle after `rsp0_ready`=1.
- Illegal op 4'b0000 with a=7, b=7 → result=0, illegal=1, zero=0. sll with b=32 → result=0.
- Assert `rst_n`=0 during EXEC → the next cycle shows the reset values and no response. After release, tied requests grant requester 0 first.
